axis_packet_gen: RTL and testbench

Synthesisable, parametrised AXI-Stream packet generator: the hardware successor to our bench-only stream source. Emits one packet of a programmable word count per `start`, packing `WORDS_PER_BEAT` words per beat with `m_keep`/`m_last` on the final beat. It inserts LFSR-driven random valid gaps while obeying AXIS hold rules. It sits ahead of the systolic-array input stream in on-chip self-test and FPGA bring-up, and drives sinks in simulation.

---
 rtl/axis_gen_pkg.sv | 25 ++
 rtl/lfsr16.sv | 36 +++
 rtl/axis_packet_gen.sv | 195 +++++++++++++++++++
 tb/tb_axis_packet_gen.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_gen_pkg.sv
// Shared types and constants for the AXI-Stream packet generator and
// for the checker that will later track the same throttle sequence.
package axis_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } gen_state_t;

    typedef enum logic {
        MODE_INC = 1'b0,
        MODE_DEC = 1'b1
    } gen_mode_t;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] shifted;
        shifted = s >> 1;
        return s[0] ? (shifted ^ LFSR_TAPS) : shifted;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with a parameterised reset seed. The seed must be
// non-zero, otherwise the register locks at zero.
module lfsr16
    import axis_gen_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Advance one step whenever enabled.
    always_comb begin
        state_d = state_q;
        if (en) begin
            state_d = lfsr_step(state_q);
        end
    end

    // State register, reloaded with the seed on reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/axis_packet_gen.sv
// AXI-Stream packet generator. One start request produces one packet of
// n_words words (incrementing or decrementing from seed_word), packed
// WORDS_PER_BEAT per beat, lane 0 = lowest word index. Beat offers are
// throttled by a free-running LFSR; once offered, a beat is held
// unchanged until accepted. All outputs come straight from flops.
// BUS_W must be a multiple of WORD_W.
module axis_packet_gen
    import axis_gen_pkg::*;
#(
    parameter int          WORD_W         = 8,
    parameter int          BUS_W          = 32,
    parameter int          MAX_WORDS      = 1024,
    parameter int          PROB_VALID     = 100,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    localparam int         WORDS_PER_BEAT = BUS_W / WORD_W,
    localparam int         CNT_W          = $clog2(MAX_WORDS + 1)
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   start,
    input  logic [CNT_W-1:0]                       n_words,
    input  logic                                   mode,
    input  logic [WORD_W-1:0]                      seed_word,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic [WORDS_PER_BEAT-1:0][WORD_W-1:0]  m_data,
    output logic [WORDS_PER_BEAT-1:0]              m_keep,
    output logic                                   m_last,
    output logic                                   dbg_state
);

    // k is one bit wider than the length so k + lane never wraps.
    localparam int            KW           = CNT_W + 1;
    localparam int            AW           = (KW > WORD_W) ? KW : WORD_W;
    localparam logic [KW-1:0] WPB_K        = KW'(WORDS_PER_BEAT);
    localparam logic [7:0]    VALID_THRESH = 8'((PROB_VALID * 128) / 100);

    // Handshake contract: a beat transfers on a rising edge where
    // m_valid && m_ready; while m_valid is high and m_ready is low the
    // beat (m_valid, m_data, m_keep, m_last) is frozen.

    gen_state_t                          state_q, state_d;
    logic [KW-1:0]                       k_q, k_d;
    logic [CNT_W-1:0]                    n_q, n_d;
    gen_mode_t                           mode_q, mode_d;
    logic [WORD_W-1:0]                   seed_q, seed_d;
    logic                                valid_q, valid_d;
    logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] data_q, data_d;
    logic [WORDS_PER_BEAT-1:0]           keep_q, keep_d;
    logic                                last_q, last_d;
    logic                                done_q, done_d;

    logic [15:0]                         lfsr_state;
    logic                                lfsr_unused;
    logic                                lfsr_ok;
    logic                                handshake;
    logic [KW-1:0]                       n_ext;
    logic [KW-1:0]                       k_next;
    logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] lane_data;
    logic [WORDS_PER_BEAT-1:0]           lane_keep;
    logic                                lane_last;

    // Word value at absolute index idx, modulo 2^WORD_W.
    function automatic logic [WORD_W-1:0] word_at(
        input logic [WORD_W-1:0] seed,
        input gen_mode_t         md,
        input logic [KW-1:0]     idx
    );
        logic [AW-1:0] sum;
        if (md == MODE_DEC) begin
            sum = AW'(seed) - AW'(idx);
        end else begin
            sum = AW'(seed) + AW'(idx);
        end
        return sum[WORD_W-1:0];
    endfunction

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rstn  (rstn),
        .en    (1'b1),
        .state (lfsr_state)
    );

    assign lfsr_unused = ^lfsr_state[15:7];
    assign lfsr_ok     = ({1'b0, lfsr_state[6:0]} < VALID_THRESH);
    assign handshake   = valid_q && m_ready;
    assign n_ext       = {1'b0, n_q};
    // Index of the first word of the beat that may be offered this edge.
    assign k_next      = (handshake && !last_q) ? (k_q + WPB_K) : k_q;

    // Lane fill: build the candidate beat starting at word k_next.
    always_comb begin
        lane_data = '0;
        lane_keep = '0;
        lane_last = ((n_ext - k_next) <= WPB_K);
        for (int i = 0; i < WORDS_PER_BEAT; i++) begin
            if ((k_next + KW'(i)) < n_ext) begin
                lane_keep[i] = 1'b1;
                lane_data[i] = word_at(seed_q, mode_q, k_next + KW'(i));
            end
        end
    end

    // Next-state, counter and output-register logic.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        mode_d  = mode_q;
        seed_d  = seed_q;
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (n_words != '0) begin
                        state_d = RUN;
                        k_d     = '0;
                        n_d     = n_words;
                        mode_d  = gen_mode_t'(mode);
                        seed_d  = seed_word;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (handshake && last_q) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    data_d  = '0;
                    keep_d  = '0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    k_d = k_next;
                    if ((!valid_q || handshake) && (k_next < n_ext) && lfsr_ok) begin
                        valid_d = 1'b1;
                        data_d  = lane_data;
                        keep_d  = lane_keep;
                        last_d  = lane_last;
                    end else if (handshake) begin
                        valid_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any packet in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            k_q     <= '0;
            n_q     <= '0;
            mode_q  <= MODE_INC;
            seed_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            mode_q  <= mode_d;
            seed_q  <= seed_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign m_valid   = valid_q;
    assign m_data    = data_q;
    assign m_keep    = keep_q;
    assign m_last    = last_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_axis_packet_gen.sv
// Directed bench for axis_packet_gen: a full-rate instance for timing and
// packing checks, and a PROB_VALID=30 instance driven with random m_ready
// for the hold-rule and long-packet wrap checks.
module tb_axis_packet_gen;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // ---------------- full-rate instance ----------------
    logic            start = 1'b0;
    logic [10:0]     n_words = '0;
    logic            mode = 1'b0;
    logic [7:0]      seed_word = '0;
    logic            busy, done, m_valid, m_last, dbg_state;
    logic            m_ready = 1'b1;
    logic [3:0][7:0] m_data;
    logic [3:0]      m_keep;

    axis_packet_gen u_dut (
        .clk(clk), .rstn(rstn), .start(start), .n_words(n_words), .mode(mode),
        .seed_word(seed_word), .busy(busy), .done(done), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
        .dbg_state(dbg_state)
    );

    // ---------------- throttled instance ----------------
    logic            r_start = 1'b0;
    logic [10:0]     r_n_words = '0;
    logic            r_mode = 1'b0;
    logic [7:0]      r_seed_word = '0;
    logic            r_busy, r_done, r_m_valid, r_m_last, r_dbg_state;
    logic            r_m_ready = 1'b0;
    logic [3:0][7:0] r_m_data;
    logic [3:0]      r_m_keep;

    axis_packet_gen #(.PROB_VALID(30)) u_dut30 (
        .clk(clk), .rstn(rstn), .start(r_start), .n_words(r_n_words), .mode(r_mode),
        .seed_word(r_seed_word), .busy(r_busy), .done(r_done), .m_valid(r_m_valid),
        .m_ready(r_m_ready), .m_data(r_m_data), .m_keep(r_m_keep), .m_last(r_m_last),
        .dbg_state(r_dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int vec  = 0;
    int miss = 0;
    logic [36:0] exp_q[$];

    // ---------------- driver tasks ----------------
    // Returns just after the edge that samples start (edge N).
    task automatic pulse_start(input logic [10:0] n, input logic md, input logic [7:0] sd);
        @(negedge clk);
        start = 1'b1; n_words = n; mode = md; seed_word = sd;
        @(negedge clk);
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        vec++;
        if ({busy, done, m_valid, m_last, m_keep, m_data, dbg_state} !== 40'h0) begin
            miss++;
            $display("FAIL reset_held: got %h want 0",
                     {busy, done, m_valid, m_last, m_keep, m_data, dbg_state});
        end
        rstn = 1'b1;
        @(negedge clk);
        vec++;
        if ({busy, done, m_valid, m_last, m_keep, m_data, dbg_state} !== 40'h0) begin
            miss++;
            $display("FAIL reset_release: got %h want 0",
                     {busy, done, m_valid, m_last, m_keep, m_data, dbg_state});
        end
    endtask

    task automatic test_inc();
        m_ready = 1'b1;
        pulse_start(11'd8, 1'b0, 8'h10);
        vec++;
        if ({busy, m_valid} !== 2'b10) begin
            miss++; $display("FAIL inc_busy: got %b want 10", {busy, m_valid});
        end
        @(negedge clk);
        vec++;
        if ({m_valid, m_last, m_keep, m_data} !== {1'b1, 1'b0, 4'hF, 32'h13121110}) begin
            miss++; $display("FAIL inc_beat0: got %h want %h", {m_valid, m_last, m_keep, m_data},
                             {1'b1, 1'b0, 4'hF, 32'h13121110});
        end
        @(negedge clk);
        vec++;
        if ({m_valid, m_last, m_keep, m_data} !== {1'b1, 1'b1, 4'hF, 32'h17161514}) begin
            miss++; $display("FAIL inc_beat1: got %h want %h", {m_valid, m_last, m_keep, m_data},
                             {1'b1, 1'b1, 4'hF, 32'h17161514});
        end
        @(negedge clk);
        vec++;
        if ({busy, done, m_valid} !== 3'b010) begin
            miss++; $display("FAIL inc_done: got %b want 010", {busy, done, m_valid});
        end
        @(negedge clk);
        vec++;
        if ({busy, done, m_valid} !== 3'b000) begin
            miss++; $display("FAIL inc_done_pulse: got %b want 000", {busy, done, m_valid});
        end
    endtask

    task automatic test_dec_partial();
        pulse_start(11'd6, 1'b1, 8'h05);
        @(negedge clk);
        vec++;
        if ({m_valid, m_last, m_keep, m_data} !== {1'b1, 1'b0, 4'hF, 32'h02030405}) begin
            miss++; $display("FAIL dec_beat0: got %h want %h", {m_valid, m_last, m_keep, m_data},
                             {1'b1, 1'b0, 4'hF, 32'h02030405});
        end
        @(negedge clk);
        vec++;
        if ({m_valid, m_last, m_keep, m_data} !== {1'b1, 1'b1, 4'h3, 32'h00000001}) begin
            miss++; $display("FAIL dec_beat1: got %h want %h", {m_valid, m_last, m_keep, m_data},
                             {1'b1, 1'b1, 4'h3, 32'h00000001});
        end
        @(negedge clk);
        vec++;
        if ({busy, done, m_valid} !== 3'b010) begin
            miss++; $display("FAIL dec_done: got %b want 010", {busy, done, m_valid});
        end
    endtask

    task automatic test_zero_len();
        pulse_start(11'd0, 1'b0, 8'h77);
        vec++;
        if ({busy, done, m_valid} !== 3'b010) begin
            miss++; $display("FAIL zero_done: got %b want 010", {busy, done, m_valid});
        end
        @(negedge clk);
        vec++;
        if ({busy, done, m_valid} !== 3'b000) begin
            miss++; $display("FAIL zero_after: got %b want 000", {busy, done, m_valid});
        end
    endtask

    task automatic test_back_to_back();
        m_ready = 1'b0;
        pulse_start(11'd4, 1'b0, 8'h20);
        @(negedge clk);
        vec++;
        if ({m_valid, m_last, m_keep, m_data} !== {1'b1, 1'b1, 4'hF, 32'h23222120}) begin
            miss++; $display("FAIL b2b_first: got %h want %h", {m_valid, m_last, m_keep, m_data},
                             {1'b1, 1'b1, 4'hF, 32'h23222120});
        end
        // start while busy: must be ignored, beat held
        start = 1'b1; n_words = 11'd8; seed_word = 8'h99;
        @(negedge clk);
        start = 1'b0;
        vec++;
        if ({busy, m_valid, m_last, m_keep, m_data} !== {1'b1, 1'b1, 1'b1, 4'hF, 32'h23222120}) begin
            miss++; $display("FAIL b2b_ignored: got %h want %h", {busy, m_valid, m_last, m_keep, m_data},
                             {1'b1, 1'b1, 1'b1, 4'hF, 32'h23222120});
        end
        m_ready = 1'b1;
        @(negedge clk);
        vec++;
        if ({busy, done, m_valid} !== 3'b010) begin
            miss++; $display("FAIL b2b_done: got %b want 010", {busy, done, m_valid});
        end
        // start in the done cycle is accepted
        start = 1'b1; n_words = 11'd4; mode = 1'b0; seed_word = 8'h40;
        @(negedge clk);
        start = 1'b0;
        vec++;
        if ({busy, done, m_valid} !== 3'b100) begin
            miss++; $display("FAIL b2b_restart: got %b want 100", {busy, done, m_valid});
        end
        @(negedge clk);
        vec++;
        if ({m_valid, m_last, m_keep, m_data} !== {1'b1, 1'b1, 4'hF, 32'h43424140}) begin
            miss++; $display("FAIL b2b_second: got %h want %h", {m_valid, m_last, m_keep, m_data},
                             {1'b1, 1'b1, 4'hF, 32'h43424140});
        end
        @(negedge clk);
        vec++;
        if ({busy, done, m_valid} !== 3'b010) begin
            miss++; $display("FAIL b2b_second_done: got %b want 010", {busy, done, m_valid});
        end
    endtask

    task automatic test_start_collision();
        m_ready = 1'b0;
        pulse_start(11'd2, 1'b0, 8'hA0);
        @(negedge clk);
        // final handshake and start on the same edge: start is ignored
        m_ready = 1'b1; start = 1'b1; n_words = 11'd4; seed_word = 8'h55;
        @(negedge clk);
        start = 1'b0;
        vec++;
        if ({busy, done, m_valid} !== 3'b010) begin
            miss++; $display("FAIL coll_done: got %b want 010", {busy, done, m_valid});
        end
        @(negedge clk);
        vec++;
        if ({busy, done, m_valid} !== 3'b000) begin
            miss++; $display("FAIL coll_ignored: got %b want 000", {busy, done, m_valid});
        end
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b1;
        pulse_start(11'd40, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        vec++;
        if ({m_valid, m_last, m_keep, m_data} !== {1'b1, 1'b0, 4'hF, 32'h0B0A0908}) begin
            miss++; $display("FAIL rst_beat2: got %h want %h", {m_valid, m_last, m_keep, m_data},
                             {1'b1, 1'b0, 4'hF, 32'h0B0A0908});
        end
        rstn = 1'b0;
        #1;
        vec++;
        if ({busy, m_valid, done} !== 3'b000) begin
            miss++; $display("FAIL rst_abort: got %b want 000", {busy, m_valid, done});
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec++;
            if ({busy, done, m_valid} !== 3'b000) begin
                miss++; $display("FAIL rst_no_done: got %b want 000", {busy, done, m_valid});
            end
        end
        pulse_start(11'd8, 1'b0, 8'h00);
        @(negedge clk);
        vec++;
        if ({m_valid, m_last, m_keep, m_data} !== {1'b1, 1'b0, 4'hF, 32'h03020100}) begin
            miss++; $display("FAIL rst_fresh0: got %h want %h", {m_valid, m_last, m_keep, m_data},
                             {1'b1, 1'b0, 4'hF, 32'h03020100});
        end
        @(negedge clk);
        vec++;
        if ({m_valid, m_last, m_keep, m_data} !== {1'b1, 1'b1, 4'hF, 32'h07060504}) begin
            miss++; $display("FAIL rst_fresh1: got %h want %h", {m_valid, m_last, m_keep, m_data},
                             {1'b1, 1'b1, 4'hF, 32'h07060504});
        end
        @(negedge clk);
        vec++;
        if ({busy, done, m_valid} !== 3'b010) begin
            miss++; $display("FAIL rst_fresh_done: got %b want 010", {busy, done, m_valid});
        end
    endtask

    task automatic test_throttled_long();
        logic [7:0]  w;
        logic [36:0] obs, prev_obs, exp;
        logic        prev_valid, prev_ready, finished;
        exp_q.delete();
        for (int b = 0; b < 256; b++) begin
            w = 8'hF0 + 8'(4 * b);
            exp_q.push_back({(b == 255), 4'hF, w + 8'd3, w + 8'd2, w + 8'd1, w});
        end
        @(negedge clk);
        r_start = 1'b1; r_n_words = 11'd1024; r_mode = 1'b0; r_seed_word = 8'hF0;
        @(negedge clk);
        r_start = 1'b0;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_obs = '0; finished = 1'b0;
        for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
            @(negedge clk);
            obs = {r_m_last, r_m_keep, r_m_data};
            if (prev_valid && !prev_ready) begin
                vec++;
                if (!r_m_valid || obs !== prev_obs) begin
                    miss++; $display("FAIL rnd_hold: got v=%b %h want v=1 %h", r_m_valid, obs, prev_obs);
                end
            end
            if (prev_valid && prev_ready) begin
                vec++;
                if (exp_q.size() == 0) begin
                    miss++; $display("FAIL rnd_extra: got beat %h want none", prev_obs);
                    finished = 1'b1;
                end else begin
                    exp = exp_q.pop_front();
                    if (prev_obs !== exp) begin
                        miss++; $display("FAIL rnd_beat: got %h want %h", prev_obs, exp);
                    end
                    if (exp[36]) begin
                        vec++;
                        if ({r_busy, r_done, r_m_valid} !== 3'b010) begin
                            miss++; $display("FAIL rnd_done: got %b want 010", {r_busy, r_done, r_m_valid});
                        end
                        finished = 1'b1;
                    end
                end
            end
            prev_valid = r_m_valid;
            r_m_ready  = 1'($urandom_range(0, 1));
            prev_ready = r_m_ready;
            prev_obs   = obs;
        end
        vec++;
        if (!finished || exp_q.size() != 0) begin
            miss++; $display("FAIL rnd_timeout: got %0d beats left want 0", exp_q.size());
        end
        r_m_ready = 1'b0;
    endtask

    // ---------------- sequencer / final report ----------------
    initial begin
        test_reset();
        test_inc();
        test_dec_partial();
        test_zero_len();
        test_back_to_back();
        test_start_collision();
        test_throttled_long();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
